// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot counter family: gate FSM encoding
// and the default lot dimensions used by the counter, display and subtractor blocks.
package parking_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_e;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_CAPACITY = 10;

endpackage

// File: rtl/parking_occupancy_counter_full_adder.sv
// One-bit full adder cell; port order matches the full_subtractor cell so the
// two ripple datapaths read the same way.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/parking_occupancy_counter.sv
// Lot occupancy counter: edge-detects the gate sensors, drives the entry gate
// FSM and updates the count through a ripple adder built from full_adder cells.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CAPACITY = DEFAULT_CAPACITY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enter_sensor,
  input  logic             exit_sensor,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] free_spaces,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             denied,
  output logic             underflow_err
);

  localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

  gate_state_e      state_q, state_d;
  logic             enter_prev, exit_prev;
  logic             enter_rise, exit_rise;
  logic             accept_entry, deny_entry;
  logic             take_exit, underflow_hit;
  logic [WIDTH-1:0] count_q, count_d, addend;
  logic [WIDTH:0]   count_carry, free_carry;
  logic             count_carry_unused, free_carry_unused;

  assign enter_rise = enter_sensor & ~enter_prev;
  assign exit_rise  = exit_sensor & ~exit_prev;

  assign count = count_q;
  assign full  = (count_q == CAP_W);
  assign empty = (count_q == '0);

  // Full/empty are judged on the pre-update count, so a simultaneous exit
  // never makes room for an entry arriving in the same cycle.
  assign take_exit     = exit_rise & ~empty;
  assign underflow_hit = exit_rise & empty;

  always_comb begin
    state_d      = state_q;
    accept_entry = 1'b0;
    deny_entry   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_rise) begin
          if (full) begin
            deny_entry = 1'b1;
          end else begin
            accept_entry = 1'b1;
            state_d      = OPEN;
          end
        end
      end
      OPEN: begin
        if (!enter_sensor) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An accepted entry and exit together cancel out, leaving the addend at zero.
  always_comb begin
    addend = '0;
    if (accept_entry && !take_exit) begin
      addend = WIDTH'(1);
    end else if (take_exit && !accept_entry) begin
      addend = '1;
    end
  end

  assign count_carry[0] = 1'b0;
  assign free_carry[0]  = 1'b1;

  // free_spaces = CAPACITY - count, formed as CAPACITY + ~count + 1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
    full_adder u_count_fa (
      .a         (count_q[gi]),
      .b         (addend[gi]),
      .carry_in  (count_carry[gi]),
      .sum       (count_d[gi]),
      .carry_out (count_carry[gi+1])
    );

    full_adder u_free_fa (
      .a         (CAP_W[gi]),
      .b         (~count_q[gi]),
      .carry_in  (free_carry[gi]),
      .sum       (free_spaces[gi]),
      .carry_out (free_carry[gi+1])
    );
  end

  assign count_carry_unused = count_carry[WIDTH];
  assign free_carry_unused  = free_carry[WIDTH];

  // Prev registers reset high so a sensor already active at release is not an event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      gate_open     <= 1'b0;
      denied        <= 1'b0;
      underflow_err <= 1'b0;
      enter_prev    <= 1'b1;
      exit_prev     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gate_open  <= (state_d == OPEN);
      denied     <= deny_entry;
      enter_prev <= enter_sensor;
      exit_prev  <= exit_sensor;
      if (underflow_hit) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares them just after the next rising edge.
module tb_parking_occupancy_counter;

  localparam int WIDTH    = 4;
  localparam int CAPACITY = 3;

  typedef struct {
    int cars;
    int free;
    bit full;
    bit empty;
    bit gate;
    bit denied;
    bit underflow;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             enter_sensor;
  logic             exit_sensor;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] free_spaces;
  logic             full;
  logic             empty;
  logic             gate_open;
  logic             denied;
  logic             underflow_err;

  expect_t exp_q[$];
  int      checks;
  int      errors;

  // Reference model state: a car tally plus gate/flag bookkeeping.
  int cars;
  bit gate_is_open;
  bit deny_now;
  bit err_seen;
  bit last_enter;
  bit last_exit;

  parking_occupancy_counter #(
    .WIDTH    (WIDTH),
    .CAPACITY (CAPACITY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enter_sensor  (enter_sensor),
    .exit_sensor   (exit_sensor),
    .count         (count),
    .free_spaces   (free_spaces),
    .full          (full),
    .empty         (empty),
    .gate_open     (gate_open),
    .denied        (denied),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit rst_v, input bit en_v, input bit ex_v);
    expect_t e;
    bit car_arrives;
    bit car_leaves;
    int change;
    if (!rst_v) begin
      cars         = 0;
      gate_is_open = 1'b0;
      deny_now     = 1'b0;
      err_seen     = 1'b0;
      last_enter   = 1'b1;
      last_exit    = 1'b1;
    end else begin
      car_arrives = en_v && !last_enter;
      car_leaves  = ex_v && !last_exit;
      change      = 0;
      deny_now    = 1'b0;
      if (gate_is_open) begin
        if (!en_v) gate_is_open = 1'b0;
      end else if (car_arrives) begin
        if (cars >= CAPACITY) begin
          deny_now = 1'b1;
        end else begin
          change       = change + 1;
          gate_is_open = 1'b1;
        end
      end
      if (car_leaves) begin
        if (cars > 0) change = change - 1;
        else err_seen = 1'b1;
      end
      cars       = cars + change;
      last_enter = en_v;
      last_exit  = ex_v;
    end
    e.cars      = cars;
    e.free      = CAPACITY - cars;
    e.full      = (cars == CAPACITY);
    e.empty     = (cars == 0);
    e.gate      = gate_is_open;
    e.denied    = deny_now;
    e.underflow = err_seen;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit rst_v, input bit en_v, input bit ex_v);
    @(negedge clk);
    rst_n        = rst_v;
    enter_sensor = en_v;
    exit_sensor  = ex_v;
    model_step(rst_v, en_v, ex_v);
  endtask

  task automatic apply_cycles(input int n, input bit rst_v, input bit en_v, input bit ex_v);
    for (int i = 0; i < n; i++) apply_stimulus(rst_v, en_v, ex_v);
  endtask

  task automatic check_field(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
    end
  endtask

  task automatic check_output(input expect_t e);
    check_field("count", int'(count), e.cars);
    check_field("free_spaces", int'(free_spaces), e.free);
    check_field("full", int'(full), int'(e.full));
    check_field("empty", int'(empty), int'(e.empty));
    check_field("gate_open", int'(gate_open), int'(e.gate));
    check_field("denied", int'(denied), int'(e.denied));
    check_field("underflow_err", int'(underflow_err), int'(e.underflow));
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    int hold_en;
    int hold_ex;
    bit lvl_en;
    bit lvl_ex;
    int wait_cycles;

    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    enter_sensor = 1'b1;
    exit_sensor  = 1'b1;

    // Reset with both sensors high, release and keep them high: no event.
    apply_cycles(2, 1'b0, 1'b1, 1'b1);
    apply_cycles(5, 1'b1, 1'b1, 1'b1);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);

    // Fill the lot, then one more pulse that must be denied.
    for (int p = 0; p < 4; p++) begin
      apply_cycles(4, 1'b1, 1'b1, 1'b0);
      apply_cycles(2, 1'b1, 1'b0, 1'b0);
    end

    // Full lot: entry and exit together -> denied, count drops, then refill.
    apply_cycles(2, 1'b1, 1'b1, 1'b1);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);
    apply_cycles(4, 1'b1, 1'b1, 1'b0);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);

    // Drain past empty to raise the sticky underflow flag, then reset it.
    for (int p = 0; p < 4; p++) begin
      apply_cycles(1, 1'b1, 1'b0, 1'b1);
      apply_cycles(2, 1'b1, 1'b0, 1'b0);
    end
    apply_cycles(3, 1'b1, 1'b0, 1'b0);
    apply_cycles(1, 1'b0, 1'b0, 1'b0);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);

    // count=1, simultaneous entry/exit keeps it at 1; reset while the gate is open.
    apply_cycles(3, 1'b1, 1'b1, 1'b0);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);
    apply_cycles(2, 1'b1, 1'b1, 1'b1);
    apply_cycles(1, 1'b0, 1'b1, 1'b1);
    apply_cycles(3, 1'b1, 1'b1, 1'b0);
    apply_cycles(2, 1'b1, 1'b0, 1'b0);

    // Random sensor traffic with occasional resets.
    hold_en = 0;
    hold_ex = 0;
    lvl_en  = 1'b0;
    lvl_ex  = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (hold_en == 0) begin
        lvl_en  = ~lvl_en;
        hold_en = $urandom_range(1, 5);
      end
      if (hold_ex == 0) begin
        lvl_ex  = ~lvl_ex;
        hold_ex = $urandom_range(1, 7);
      end
      hold_en--;
      hold_ex--;
      apply_stimulus(($urandom_range(0, 99) != 0), lvl_en, lvl_ex);
    end

    apply_cycles(2, 1'b1, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
Tracks the number of cars inside the lot. Increments on entry and decrements on exit through a ripple adder datapath built from full-adder cells; this is the add-side counterpart of the existing full-subtractor counter path. Drives the entry gate through a small FSM, refuses entry when the lot is full, and flags exit events seen while the lot is empty. Sits between the debounced gate sensors and the display/free-space logic.

Parameters:
WIDTH, 4, bit width of the occupancy count; must satisfy CAPACITY <= 2^WIDTH - 1
CAPACITY, 10, number of parking spaces; count saturates here

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
enter_sensor  input  1  debounced entry-gate sensor level, synchronous to clk
exit_sensor  input  1  debounced exit-gate sensor level, synchronous to clk
count  output  WIDTH  cars currently inside
free_spaces  output  WIDTH  CAPACITY - count
full  output  1  count == CAPACITY
empty  output  1  count == 0
gate_open  output  1  entry gate open command
denied  output  1  one-cycle pulse: entry refused because the lot is full
underflow_err  output  1  sticky: exit edge seen while count == 0

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, set count=0, gate_open=0, denied=0, underflow_err=0, FSM=IDLE.
- Reset also sets enter_prev=1 and exit_prev=1. A sensor already high at reset release therefore produces no event.
- Edge detect: enter_rise = enter_sensor & ~enter_prev. exit_rise = exit_sensor & ~exit_prev. Both prev registers update every cycle.
- free_spaces, full and empty are combinational from the count register. After reset: free_spaces=CAPACITY, empty=1, full=0.
- Gate FSM, states IDLE and OPEN:
  - IDLE, enter_rise, full=0: next cycle count+1, gate_open=1, state OPEN.
  - IDLE, enter_rise, full=1: next cycle denied=1 for exactly one cycle, count unchanged, state stays IDLE.
  - OPEN, enter_sensor=1: stay OPEN, gate_open=1.
  - OPEN, enter_sensor=0: next cycle gate_open=0, state IDLE.
  - enter_rise while in OPEN: ignored, no second increment. This cannot occur while the sensor stays high.
- Exit handling is independent of the FSM:
  - exit_rise with count>0: count-1 next cycle.
  - exit_rise with count==0: count stays 0, underflow_err=1 and holds until reset.
- Latency: one cycle from the sensor edge cycle to count, gate_open and denied changing.
- Simultaneous accepted entry and exit in the same cycle: net change 0, count unchanged, gate_open still asserts.
- Simultaneous entry and exit when full: full is judged on the pre-update count, so entry is denied and the exit decrements. Next count = CAPACITY-1, denied pulses.
- Simultaneous entry and exit when empty: entry accepted, exit flags underflow_err. Next count = 1.
- Arithmetic:
  - Next count = count + addend, computed by a WIDTH-bit ripple adder with carry-in 0.
  - addend = 1 for increment only; all-ones (two's complement -1) for decrement only; 0 otherwise.
  - Carry-out is discarded. Saturation at CAPACITY and the floor at 0 are guaranteed by the accept conditions, never by wrap-around.
- free_spaces is computed with the same adder: CAPACITY + ~count + 1, sharing the full_adder cell.
- Reset asserted mid-operation (gate open, sensor high) returns every output to its reset value on that edge. No event is generated until the sensor falls and rises again.

Decomposition:
- Shared package or header `parking_pkg`:
  - FSM state encodings: IDLE=1'b0, OPEN=1'b1.
  - Default CAPACITY and WIDTH constants, shared with the display and subtractor counter blocks.
- One sub-module, full_adder (a, b, carry_in, sum, carry_out), mirroring the port order of full_subtractor. Instantiate it WIDTH times with a generate loop for each of the two ripple adders.
- The FSM and edge detectors stay in the top module.

Test Plan:
- Bench overrides CAPACITY=3, WIDTH=4 for every scenario.
- Reset with both sensors held high, release, hold high 5 cycles -> count=0, free_spaces=3, empty=1, gate_open=0, no event.
- Three full enter pulses (high 4 cycles, low 2) -> count 1,2,3 each one cycle after the rise; gate_open high from rise+1 until one cycle after the fall; full=1, free_spaces=0 at the end.
- At count=3, fourth enter pulse -> denied=1 for exactly one cycle, count stays 3, gate_open stays 0.
- At count=3, enter and exit rising in the same cycle -> next cycle count=2, denied=1. Then a new enter pulse -> count=3, gate_open=1.
- Four exits from count=3 -> count 2,1,0, then underflow_err=1 on the 4th with count held at 0. underflow_err remains 1 until rst_n=0, then clears.
- count=1, enter and exit rising in the same cycle -> count stays 1, gate_open=1. Assert rst_n=0 while OPEN -> next edge count=0, gate_open=0, FSM IDLE.
